// File: rtl/avalon_uart_pkg.sv
// rtl/avalon_uart_pkg.sv - shared address map and slave FSM encoding for the UART/Avalon path
//
// Purpose: register addresses and the Avalon slave transfer-state enum used by
//          avalon_uart_regbank (and the upstream bridge). No ports.
package avalon_uart_pkg;

  localparam logic [31:0] ADDR_CMD  = 32'h0000_0000;
  localparam logic [31:0] ADDR_ADDR = 32'h0000_0004;
  localparam logic [31:0] ADDR_DATA = 32'h0000_0008;
  localparam logic [31:0] ADDR_TX   = 32'h0000_000C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } slave_state_t;

  // Word-aligned and inside the 16-byte window.
  function automatic logic addr_mapped(input logic [31:0] addr);
    return (addr[31:4] == 28'd0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/avalon_uart_regbank_if.sv
// rtl/avalon_uart_regbank_if.sv - Avalon-MM bus bundle between the UART bridge and the register bank
//
// Purpose: groups the Avalon-MM master/slave signals.
// Signals: ADDRESS, WRITEDATA, READ, WRITE, BEGINTRANSFER, LOCK (master -> slave);
//          READDATA, WAITREQUEST (slave -> master).
interface avalon_uart_regbank_if;

  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic        READ;
  logic        WRITE;
  logic        BEGINTRANSFER;
  logic        LOCK;
  logic [31:0] READDATA;
  logic        WAITREQUEST;

  modport master (
    output ADDRESS, WRITEDATA, READ, WRITE, BEGINTRANSFER, LOCK,
    input  READDATA, WAITREQUEST
  );

  modport slave (
    input  ADDRESS, WRITEDATA, READ, WRITE, BEGINTRANSFER, LOCK,
    output READDATA, WAITREQUEST
  );

endinterface

// File: rtl/avalon_uart_regbank.sv
// rtl/avalon_uart_regbank.sv - Avalon-MM slave register bank for inbound UART packets and the outbound TX word
//
// Purpose: R0..R2 (0x0/0x4/0x8) receive the three inbound words; once all three
//          have been written, pkt_valid pulses for one cycle. R3 (0xC) is loaded by
//          the core and read by the bridge; tx_pending flags unread data.
// Ports:   CLK, RST (async, active high)
//          av            Avalon-MM slave modport (ADDRESS, WRITEDATA, READ, WRITE,
//                        BEGINTRANSFER, LOCK, READDATA, WAITREQUEST)
//          pkt_valid     one-cycle packet strobe; pkt_cmd/pkt_addr/pkt_data = R0/R1/R2
//          core_tx_wr    core write strobe for R3, core_tx_data its data
//          core_busy     core write ignored this cycle
//          tx_pending    R3 holds unread data
module avalon_uart_regbank
  import avalon_uart_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 1,
  parameter logic [31:0] BAD_READ_VALUE = 32'h0000_0000
) (
  input  logic                         CLK,
  input  logic                         RST,
  avalon_uart_regbank_if.slave         av,
  output logic                         pkt_valid,
  output logic [31:0]                  pkt_cmd,
  output logic [31:0]                  pkt_addr,
  output logic [31:0]                  pkt_data,
  input  logic                         core_tx_wr,
  input  logic [31:0]                  core_tx_data,
  output logic                         core_busy,
  output logic                         tx_pending
);

  slave_state_t state;
  logic [3:0]   wait_cnt;
  logic [31:0]  addr_q;
  logic [31:0]  regs [4];
  logic [2:0]   wr_mask;
  logic [2:0]   wr_mask_next;
  logic         lock_held;
  logic [31:0]  rdata_q;

  logic         req;
  logic         capture;
  logic         ack_go;
  logic         ack_reg_wr;
  logic [1:0]   ack_idx;
  logic [31:0]  rd_value;
  logic         unused_ok;

  assign req = av.READ | av.WRITE;

  // The IDLE cycle in which the request first appears is stall cycle 0, so the
  // counter starts at 1 on entry to WAIT and a single wait state skips WAIT.
  assign capture = req &&
                   (((state == S_IDLE) && (WAIT_STATES == 1)) ||
                    ((state == S_WAIT) && (wait_cnt == 4'(WAIT_STATES - 1))));

  assign ack_go     = (state == S_ACK) && req;
  assign ack_idx    = addr_q[3:2];
  // R3 is read-only from the bus, so a write to 0xC is dropped like an unmapped one.
  assign ack_reg_wr = ack_go && av.WRITE && addr_mapped(addr_q) && (ack_idx != 2'd3);
  assign wr_mask_next = wr_mask | (3'b001 << ack_idx);

  // Read data is captured one cycle before ACK; the master holds ADDRESS stable.
  assign rd_value = addr_mapped(av.ADDRESS) ? regs[av.ADDRESS[3:2]] : BAD_READ_VALUE;

  assign av.WAITREQUEST = req && (state != S_ACK);
  assign av.READDATA    = rdata_q;
  assign core_busy      = tx_pending | lock_held;
  assign pkt_cmd        = regs[0];
  assign pkt_addr       = regs[1];
  assign pkt_data       = regs[2];

  assign unused_ok = av.BEGINTRANSFER;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      addr_q     <= 32'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
      wr_mask    <= 3'd0;
      pkt_valid  <= 1'b0;
      tx_pending <= 1'b0;
      lock_held  <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      pkt_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q   <= av.ADDRESS;
            wait_cnt <= 4'd1;
            state    <= (WAIT_STATES == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (capture && av.READ) rdata_q <= rd_value;

      if (ack_go) begin
        lock_held <= av.LOCK;
        if (av.READ && (addr_q == ADDR_TX)) tx_pending <= 1'b0;
      end

      if (ack_reg_wr) begin
        regs[ack_idx] <= av.WRITEDATA;
        if (wr_mask_next == 3'b111) begin
          pkt_valid <= 1'b1;
          wr_mask   <= 3'd0;
        end else begin
          wr_mask   <= wr_mask_next;
        end
      end

      // core_busy already covers a read of 0xC completing in this cycle.
      if (core_tx_wr && !core_busy) begin
        regs[3]    <= core_tx_data;
        tx_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_uart_regbank.sv
// tb/tb_avalon_uart_regbank.sv - bench for avalon_uart_regbank
module tb_avalon_uart_regbank;

  localparam logic [31:0] BAD_A = 32'hBAD0_0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  avalon_uart_regbank_if bus_a ();
  avalon_uart_regbank_if bus_b ();

  logic        pkt_valid_a, pkt_valid_b, core_tx_wr_a, core_tx_wr_b;
  logic        core_busy_a, core_busy_b, tx_pending_a, tx_pending_b;
  logic [31:0] pkt_cmd_a, pkt_addr_a, pkt_data_a, pkt_cmd_b, pkt_addr_b, pkt_data_b;
  logic [31:0] core_tx_data_a, core_tx_data_b;

  avalon_uart_regbank #(.WAIT_STATES(1), .BAD_READ_VALUE(BAD_A)) dut_a (
    .CLK(clk), .RST(rst_a), .av(bus_a.slave),
    .pkt_valid(pkt_valid_a), .pkt_cmd(pkt_cmd_a), .pkt_addr(pkt_addr_a), .pkt_data(pkt_data_a),
    .core_tx_wr(core_tx_wr_a), .core_tx_data(core_tx_data_a),
    .core_busy(core_busy_a), .tx_pending(tx_pending_a)
  );

  avalon_uart_regbank #(.WAIT_STATES(4)) dut_b (
    .CLK(clk), .RST(rst_b), .av(bus_b.slave),
    .pkt_valid(pkt_valid_b), .pkt_cmd(pkt_cmd_b), .pkt_addr(pkt_addr_b), .pkt_data(pkt_data_b),
    .core_tx_wr(core_tx_wr_b), .core_tx_data(core_tx_data_b),
    .core_busy(core_busy_b), .tx_pending(tx_pending_b)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic lk);
    if (sel) begin
      bus_b.READ = rd; bus_b.WRITE = wr; bus_b.ADDRESS = a; bus_b.WRITEDATA = d;
      bus_b.LOCK = lk; bus_b.BEGINTRANSFER = rd | wr;
    end else begin
      bus_a.READ = rd; bus_a.WRITE = wr; bus_a.ADDRESS = a; bus_a.WRITEDATA = d;
      bus_a.LOCK = lk; bus_a.BEGINTRANSFER = rd | wr;
    end
  endtask

  // One Avalon transfer; returns the stall count, READDATA in the ACK cycle and
  // pkt_valid in the cycle after ACK.
  task automatic xfer(input bit sel, input bit is_wr, input logic [31:0] a,
                      input logic [31:0] d, input logic lk,
                      output logic [31:0] rd, output int stalls, output logic pkt);
    logic wq;
    @(negedge clk);
    drive(sel, !is_wr, is_wr, a, d, lk);
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      wq = sel ? bus_b.WAITREQUEST : bus_a.WAITREQUEST;
      if (!wq) break;
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 40) check("xfer_timeout", 32'(stalls), 32'd0);
    rd = sel ? bus_b.READDATA : bus_a.READDATA;
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    pkt = sel ? pkt_valid_b : pkt_valid_a;
  endtask

  task automatic core_wr_a(input logic [31:0] d);
    @(negedge clk);
    core_tx_wr_a = 1'b1; core_tx_data_a = d;
    @(posedge clk);
    #1;
    core_tx_wr_a = 1'b0;
  endtask

  typedef enum {OP_WR, OP_RD, OP_CORE} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        lock;
    logic [31:0] exp_rd;
    logic        exp_pkt;
    logic        exp_txp;
    logic        exp_busy;
    logic [31:0] exp_p0, exp_p1, exp_p2;
  } vec_t;

  function automatic vec_t mk(op_e op, logic [31:0] addr, logic [31:0] data, logic lock,
                              logic [31:0] exp_rd, logic exp_pkt, logic exp_txp, logic exp_busy,
                              logic [31:0] p0 = 0, logic [31:0] p1 = 0, logic [31:0] p2 = 0);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.lock = lock; v.exp_rd = exp_rd;
    v.exp_pkt = exp_pkt; v.exp_txp = exp_txp; v.exp_busy = exp_busy;
    v.exp_p0 = p0; v.exp_p1 = p1; v.exp_p2 = p2;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, a, d;
    int          st;
    logic        pk;
    logic [31:0] m_regs [4];
    bit          m_written [3];
    bit          m_txp, m_lock, m_pkt, lk, is_wr;
    logic [31:0] exp_rd;
    int          op;

    vecs.push_back(mk(OP_WR,   32'h0,  32'h11, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h4,  32'h22, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h8,  32'h33, 0, 0, 1, 0, 0, 32'h11, 32'h22, 32'h33));
    vecs.push_back(mk(OP_RD,   32'h0,  0,      0, 32'h11, 0, 0, 0));
    vecs.push_back(mk(OP_RD,   32'h4,  0,      0, 32'h22, 0, 0, 0));
    vecs.push_back(mk(OP_RD,   32'h8,  0,      0, 32'h33, 0, 0, 0));
    vecs.push_back(mk(OP_CORE, 0, 32'hA5A5_0001, 0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_CORE, 0, 32'h1234_5678, 0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_RD,   32'hC,  0,      0, 32'hA5A5_0001, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h6,  32'h1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_RD,   32'h20, 0,      0, BAD_A, 0, 0, 0));
    vecs.push_back(mk(OP_RD,   32'h4,  0,      0, 32'h22, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'hC,  32'hFFFF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_RD,   32'hC,  0,      0, 32'hA5A5_0001, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h0,  32'h44, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_CORE, 0, 32'h99,      0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_RD,   32'h0,  0,      0, 32'h44, 0, 0, 0));
    vecs.push_back(mk(OP_CORE, 0, 32'h77,      0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_RD,   32'hC,  0,      0, 32'h77, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h0,  32'h55, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h4,  32'h66, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR,   32'h8,  32'h88, 0, 0, 1, 0, 0, 32'h55, 32'h66, 32'h88));

    drive(1'b0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0);
    core_tx_wr_a = 0; core_tx_data_a = 0; core_tx_wr_b = 0; core_tx_data_b = 0;
    rst_a = 1; rst_b = 1;
    repeat (2) @(negedge clk);
    check("rst_readdata", bus_a.READDATA, 32'd0);
    check("rst_waitreq", {31'd0, bus_a.WAITREQUEST}, 32'd0);
    check("rst_pkt_valid", {31'd0, pkt_valid_a}, 32'd0);
    check("rst_tx_pending", {31'd0, tx_pending_a}, 32'd0);
    check("rst_core_busy", {31'd0, core_busy_a}, 32'd0);
    check("rst_pkt_cmd", pkt_cmd_a, 32'd0);
    rst_a = 0; rst_b = 0;

    // Directed table on the single-wait-state instance.
    foreach (vecs[i]) begin
      if (vecs[i].op == OP_CORE) begin
        core_wr_a(vecs[i].data);
      end else begin
        xfer(1'b0, vecs[i].op == OP_WR, vecs[i].addr, vecs[i].data, vecs[i].lock, rd, st, pk);
        check($sformatf("v%0d_stalls", i), 32'(st), 32'd1);
        if (vecs[i].op == OP_RD) check($sformatf("v%0d_readdata", i), rd, vecs[i].exp_rd);
        check($sformatf("v%0d_pkt_valid", i), {31'd0, pk}, {31'd0, vecs[i].exp_pkt});
        if (vecs[i].exp_pkt) begin
          check($sformatf("v%0d_pkt_cmd", i), pkt_cmd_a, vecs[i].exp_p0);
          check($sformatf("v%0d_pkt_addr", i), pkt_addr_a, vecs[i].exp_p1);
          check($sformatf("v%0d_pkt_data", i), pkt_data_a, vecs[i].exp_p2);
          @(posedge clk); #1;
          check($sformatf("v%0d_pkt_width", i), {31'd0, pkt_valid_a}, 32'd0);
        end
      end
      check($sformatf("v%0d_tx_pending", i), {31'd0, tx_pending_a}, {31'd0, vecs[i].exp_txp});
      check($sformatf("v%0d_core_busy", i), {31'd0, core_busy_a}, {31'd0, vecs[i].exp_busy});
    end

    // Four wait states, reset mid-transfer, dropped command.
    xfer(1'b1, 1, 32'h0, 32'hC0, 0, rd, st, pk);
    check("b_stalls_wr", 32'(st), 32'd4);
    xfer(1'b1, 1, 32'h4, 32'hC4, 0, rd, st, pk);
    check("b_pkt_early", {31'd0, pk}, 32'd0);
    @(negedge clk);
    drive(1'b1, 0, 1, 32'h8, 32'hC8, 0);
    repeat (2) @(negedge clk);
    rst_b = 1;
    #1;
    check("b_rst_waitreq", {31'd0, bus_b.WAITREQUEST}, 32'd1);
    check("b_rst_readdata", bus_b.READDATA, 32'd0);
    check("b_rst_pkt_cmd", pkt_cmd_b, 32'd0);
    check("b_rst_pkt_addr", pkt_addr_b, 32'd0);
    check("b_rst_pkt_data", pkt_data_b, 32'd0);
    check("b_rst_pkt_valid", {31'd0, pkt_valid_b}, 32'd0);
    check("b_rst_tx_pending", {31'd0, tx_pending_b}, 32'd0);
    check("b_rst_core_busy", {31'd0, core_busy_b}, 32'd0);
    @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0);
    rst_b = 0;
    xfer(1'b1, 1, 32'h8, 32'hC8, 0, rd, st, pk);
    check("b_mask_cleared", {31'd0, pk}, 32'd0);
    xfer(1'b1, 0, 32'h8, 0, 0, rd, st, pk);
    check("b_stalls_rd", 32'(st), 32'd4);
    check("b_read_r2", rd, 32'hC8);
    @(negedge clk);
    drive(1'b1, 0, 1, 32'h0, 32'hFF, 0);
    repeat (2) @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    xfer(1'b1, 0, 32'h0, 0, 0, rd, st, pk);
    check("b_drop_no_write", rd, 32'd0);
    xfer(1'b1, 1, 32'h0, 32'h1, 0, rd, st, pk);
    check("b_pkt_after_two", {31'd0, pk}, 32'd0);
    xfer(1'b1, 1, 32'h4, 32'h2, 0, rd, st, pk);
    check("b_pkt_complete", {31'd0, pk}, 32'd1);

    // Randomized traffic against a register/flag model.
    @(negedge clk); rst_a = 1; @(negedge clk); rst_a = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    for (int i = 0; i < 3; i++) m_written[i] = 0;
    m_txp = 0; m_lock = 0;
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0: a = 32'h0; 1: a = 32'h4; 2: a = 32'h8; 3: a = 32'hC;
        4: a = 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(1, 3));
        default: a = $urandom | 32'h10;
      endcase
      d  = $urandom;
      lk = ($urandom_range(0, 3) == 0);
      if (op == 2) begin
        if (!(m_txp || m_lock)) begin m_regs[3] = d; m_txp = 1; end
        core_wr_a(d);
      end else begin
        is_wr  = (op == 0);
        m_pkt  = 0;
        exp_rd = 0;
        if (is_wr) begin
          if (a < 32'hC && a[1:0] == 0) begin
            m_regs[a / 4] = d;
            m_written[a / 4] = 1;
            if (m_written[0] && m_written[1] && m_written[2]) begin
              m_pkt = 1;
              for (int i = 0; i < 3; i++) m_written[i] = 0;
            end
          end
        end else begin
          exp_rd = (a < 32'h10 && a[1:0] == 0) ? m_regs[a / 4] : BAD_A;
          if (a == 32'hC) m_txp = 0;
        end
        m_lock = lk;
        xfer(1'b0, is_wr, a, d, lk, rd, st, pk);
        if (!is_wr) check($sformatf("r%0d_readdata", n), rd, exp_rd);
        check($sformatf("r%0d_pkt_valid", n), {31'd0, pk}, {31'd0, m_pkt});
        if (m_pkt) check($sformatf("r%0d_pkt_data", n), pkt_data_a, m_regs[2]);
      end
      check($sformatf("r%0d_tx_pending", n), {31'd0, tx_pending_a}, {31'd0, m_txp});
      check($sformatf("r%0d_core_busy", n), {31'd0, core_busy_a}, {31'd0, m_txp | m_lock});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
